// File: rtl/id_stage_if.sv
// Fetch-to-decode handshake: instruction word, its PC and valid/ready.
interface id_stage_if #(
  parameter int XLEN = 32
);
  logic            IF_VALID;
  logic [31:0]     IF_INSTR;
  logic [XLEN-1:0] IF_PC;
  logic            ID_READY;

  modport master (output IF_VALID, IF_INSTR, IF_PC, input ID_READY);
  modport slave  (input IF_VALID, IF_INSTR, IF_PC, output ID_READY);
endinterface

// File: rtl/id_stage.sv
// Instruction decode / operand fetch: field split, immediate generation,
// register scoreboard with RAW stall, and the ID/EX pipeline register.
module id_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            CLK,
  input  logic            RST,
  id_stage_if.slave       fetch,
  output logic [4:0]      RS1_ADDR,
  output logic [4:0]      RS2_ADDR,
  input  logic [XLEN-1:0] RS1_DATA,
  input  logic [XLEN-1:0] RS2_DATA,
  input  logic            WB_VALID,
  input  logic [4:0]      WB_RD,
  input  logic            FLUSH,
  input  logic            EX_READY,
  output logic            EX_VALID,
  output logic [5:0]      EX_OPC,
  output logic [4:0]      EX_RD,
  output logic            EX_WB_EN,
  output logic [XLEN-1:0] EX_RS1_VAL,
  output logic [XLEN-1:0] EX_RS2_VAL,
  output logic [XLEN-1:0] EX_IMM,
  output logic [XLEN-1:0] EX_PC,
  output logic            ILLEGAL
);

  typedef enum logic [5:0] {
    OP_NOP   = 6'd0,  OP_ADD  = 6'd1,  OP_SUB  = 6'd2,  OP_STORE = 6'd3,
    OP_LOAD  = 6'd4,  OP_MOVE = 6'd5,  OP_SGE  = 6'd6,  OP_SGT   = 6'd7,
    OP_SLE   = 6'd8,  OP_SLT  = 6'd9,  OP_SEQ  = 6'd10, OP_SNE   = 6'd11,
    OP_AND   = 6'd12, OP_OR   = 6'd13, OP_XOR  = 6'd14, OP_NOT   = 6'd15,
    OP_MOVEI = 6'd16, OP_SLI  = 6'd17, OP_SRI  = 6'd18, OP_ADDI  = 6'd19,
    OP_SUBI  = 6'd20, OP_JUMP = 6'd21, OP_BRA  = 6'd22
  } opcode_e;

  logic [5:0]      op;
  logic [4:0]      rd, rs1, rs2;
  logic [15:0]     imm16;
  logic [25:0]     tgt26;
  logic [5:0]      dec_opc;
  logic            use_rs1, use_rs2, rs2_is_rd, dec_wb, illegal;
  logic [XLEN-1:0] dec_imm, sext16;
  logic            wb_en, hazard, accept;
  logic [NREG-1:0] busy, busy_nxt;

  assign op     = fetch.IF_INSTR[31:26];
  assign rd     = fetch.IF_INSTR[25:21];
  assign rs1    = fetch.IF_INSTR[20:16];
  assign rs2    = fetch.IF_INSTR[15:11];
  assign imm16  = fetch.IF_INSTR[15:0];
  assign tgt26  = fetch.IF_INSTR[25:0];
  assign sext16 = {{(XLEN-16){imm16[15]}}, imm16};

  always_comb begin
    dec_opc   = op;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    rs2_is_rd = 1'b0;
    dec_wb    = 1'b0;
    dec_imm   = '0;
    illegal   = 1'b0;
    case (opcode_e'(op))
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_SGE, OP_SGT, OP_SLE, OP_SLT, OP_SEQ, OP_SNE,
      OP_AND, OP_OR, OP_XOR: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_wb  = 1'b1;
      end
      OP_MOVE, OP_NOT: begin
        use_rs1 = 1'b1;
        dec_wb  = 1'b1;
      end
      // Store data comes from the rd field through read port 2.
      OP_STORE: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        rs2_is_rd = 1'b1;
        dec_imm   = sext16;
      end
      OP_LOAD, OP_ADDI, OP_SUBI: begin
        use_rs1 = 1'b1;
        dec_wb  = 1'b1;
        dec_imm = sext16;
      end
      OP_MOVEI: begin
        dec_wb  = 1'b1;
        dec_imm = sext16;
      end
      OP_SLI, OP_SRI: begin
        use_rs1 = 1'b1;
        dec_wb  = 1'b1;
        dec_imm = {{(XLEN-5){1'b0}}, imm16[4:0]};
      end
      OP_JUMP: dec_imm = {{(XLEN-26){1'b0}}, tgt26};
      OP_BRA: begin
        use_rs1 = 1'b1;
        dec_imm = sext16;
      end
      default: begin
        dec_opc = '0;
        illegal = 1'b1;
      end
    endcase
  end

  assign RS1_ADDR = use_rs1 ? rs1 : '0;
  assign RS2_ADDR = use_rs2 ? (rs2_is_rd ? rd : rs2) : '0;
  assign wb_en    = dec_wb & (rd != '0);

  // Unused ports read address 0, which is never busy, so no extra gating.
  assign hazard         = busy[RS1_ADDR] | busy[RS2_ADDR];
  assign fetch.ID_READY = !RST && !FLUSH && !hazard && (!EX_VALID || EX_READY);
  assign accept         = fetch.IF_VALID & fetch.ID_READY;

  always_comb begin
    busy_nxt = busy;
    if (WB_VALID)
      busy_nxt[WB_RD] = 1'b0;
    if (FLUSH && EX_VALID && EX_WB_EN)
      busy_nxt[EX_RD] = 1'b0;
    // Applied last so a same-cycle set beats a writeback clear.
    if (accept && wb_en)
      busy_nxt[rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      EX_VALID   <= 1'b0;
      EX_OPC     <= '0;
      EX_RD      <= '0;
      EX_WB_EN   <= 1'b0;
      EX_RS1_VAL <= '0;
      EX_RS2_VAL <= '0;
      EX_IMM     <= '0;
      EX_PC      <= '0;
      ILLEGAL    <= 1'b0;
    end else begin
      ILLEGAL <= accept & illegal;
      if (FLUSH) begin
        EX_VALID <= 1'b0;
      end else if (accept) begin
        EX_VALID   <= 1'b1;
        EX_OPC     <= dec_opc;
        EX_RD      <= rd;
        EX_WB_EN   <= wb_en;
        EX_RS1_VAL <= RS1_DATA;
        EX_RS2_VAL <= RS2_DATA;
        EX_IMM     <= dec_imm;
        EX_PC      <= fetch.IF_PC;
      end else if (EX_READY) begin
        EX_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: decode vector table plus stall, flush
// and reset sequences, with an EX-side scoreboard queue.
module tb_id_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  RS1_ADDR, RS2_ADDR;
  logic [31:0] RS1_DATA, RS2_DATA;
  logic        WB_VALID;
  logic [4:0]  WB_RD;
  logic        FLUSH, EX_READY;
  logic        EX_VALID, EX_WB_EN, ILLEGAL;
  logic [5:0]  EX_OPC;
  logic [4:0]  EX_RD;
  logic [31:0] EX_RS1_VAL, EX_RS2_VAL, EX_IMM, EX_PC;

  always #5 CLK = ~CLK;

  id_stage_if #(.XLEN(32)) fetch ();

  id_stage #(.XLEN(32), .NREG(32)) dut (
    .CLK(CLK), .RST(RST), .fetch(fetch),
    .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR),
    .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA),
    .WB_VALID(WB_VALID), .WB_RD(WB_RD), .FLUSH(FLUSH), .EX_READY(EX_READY),
    .EX_VALID(EX_VALID), .EX_OPC(EX_OPC), .EX_RD(EX_RD), .EX_WB_EN(EX_WB_EN),
    .EX_RS1_VAL(EX_RS1_VAL), .EX_RS2_VAL(EX_RS2_VAL), .EX_IMM(EX_IMM),
    .EX_PC(EX_PC), .ILLEGAL(ILLEGAL)
  );

  // Register file contents: rN holds N*10, r0 reads 0.
  function automatic logic [31:0] regval(input logic [4:0] a);
    return {27'b0, a} * 32'd10;
  endfunction

  assign RS1_DATA = regval(RS1_ADDR);
  assign RS2_DATA = regval(RS2_ADDR);

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  opc;
    logic [4:0]  rd;
    logic        wb;
    logic [4:0]  ra1, ra2;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [5:0]  opc;
    logic [4:0]  rd;
    logic        wb;
    logic [31:0] rs1v, rs2v, imm, pc;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_ctr = 32'h100;
  vec_t        tbl[20];

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] d,
                                        input logic [4:0] a, input logic [4:0] b);
    return {op, d, a, b, 11'b0};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] d,
                                        input logic [4:0] a, input logic [15:0] i);
    return {op, d, a, i};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic [5:0] opc,
                              input logic [4:0] rd, input logic wb,
                              input logic [4:0] ra1, input logic [4:0] ra2,
                              input logic [31:0] imm, input logic ill);
    vec_t v;
    v.instr = instr; v.opc = opc; v.rd = rd; v.wb = wb;
    v.ra1 = ra1; v.ra2 = ra2; v.imm = imm; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input vec_t v, input logic [31:0] pc);
    exp_t e;
    e.opc = v.opc; e.rd = v.rd; e.wb = v.wb;
    e.rs1v = regval(v.ra1); e.rs2v = regval(v.ra2);
    e.imm = v.imm; e.pc = pc; e.ill = v.ill;
    sb.push_back(e);
  endtask

  task automatic drive(input vec_t v, output int waited);
    @(negedge CLK);
    fetch.IF_VALID = 1'b1;
    fetch.IF_INSTR = v.instr;
    fetch.IF_PC    = pc_ctr;
    waited = 0;
    #1;
    while (!fetch.ID_READY && waited < 20) begin
      @(negedge CLK);
      #1;
      waited++;
    end
    if (!fetch.ID_READY) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: instr %h never accepted, ready %b expected 1", v.instr, fetch.ID_READY);
      fetch.IF_VALID = 1'b0;
    end else begin
      chk("rs1_addr", {27'b0, RS1_ADDR}, {27'b0, v.ra1});
      chk("rs2_addr", {27'b0, RS2_ADDR}, {27'b0, v.ra2});
      push(v, pc_ctr);
      pc_ctr += 32'd4;
      @(posedge CLK);
    end
  endtask

  // Retire side: an EX entry is consumed when valid and ready with no flush.
  always @(negedge CLK) begin
    #2;
    if (!RST && EX_VALID && EX_READY && !FLUSH) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: EX_VALID %b with no expected entry, expected 0", EX_VALID);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ex_opc", {26'b0, EX_OPC}, {26'b0, e.opc});
        chk("ex_wb_en", {31'b0, EX_WB_EN}, {31'b0, e.wb});
        if (e.wb) chk("ex_rd", {27'b0, EX_RD}, {27'b0, e.rd});
        chk("ex_rs1_val", EX_RS1_VAL, e.rs1v);
        chk("ex_rs2_val", EX_RS2_VAL, e.rs2v);
        chk("ex_imm", EX_IMM, e.imm);
        chk("ex_pc", EX_PC, e.pc);
        chk("illegal", {31'b0, ILLEGAL}, {31'b0, e.ill});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int   w;
    vec_t va, vb, vs, vy;

    tbl[0]  = mk(itype(6'd19, 5'd3, 5'd1, 16'hFFFC), 6'd19, 5'd3, 1, 5'd1, 5'd0, 32'hFFFF_FFFC, 0);
    tbl[1]  = mk(rtype(6'd1, 5'd4, 5'd3, 5'd2), 6'd1, 5'd4, 1, 5'd3, 5'd2, 32'h0, 0);
    tbl[2]  = mk(itype(6'd17, 5'd5, 5'd1, 16'h0023), 6'd17, 5'd5, 1, 5'd1, 5'd0, 32'h3, 0);
    tbl[3]  = mk({6'd21, 26'h3FF_FFFF}, 6'd21, 5'd31, 0, 5'd0, 5'd0, 32'h03FF_FFFF, 0);
    tbl[4]  = mk(itype(6'd3, 5'd6, 5'd2, 16'h0008), 6'd3, 5'd6, 0, 5'd2, 5'd6, 32'h8, 0);
    tbl[5]  = mk(itype(6'd4, 5'd9, 5'd4, 16'h8000), 6'd4, 5'd9, 1, 5'd4, 5'd0, 32'hFFFF_8000, 0);
    tbl[6]  = mk(rtype(6'd2, 5'd10, 5'd11, 5'd12), 6'd2, 5'd10, 1, 5'd11, 5'd12, 32'h0, 0);
    tbl[7]  = mk(rtype(6'd15, 5'd13, 5'd14, 5'd7), 6'd15, 5'd13, 1, 5'd14, 5'd0, 32'h0, 0);
    tbl[8]  = mk(rtype(6'd5, 5'd15, 5'd16, 5'd3), 6'd5, 5'd15, 1, 5'd16, 5'd0, 32'h0, 0);
    tbl[9]  = mk(itype(6'd16, 5'd17, 5'd9, 16'h1234), 6'd16, 5'd17, 1, 5'd0, 5'd0, 32'h1234, 0);
    tbl[10] = mk(itype(6'd22, 5'd0, 5'd18, 16'hFFF0), 6'd22, 5'd0, 0, 5'd18, 5'd0, 32'hFFFF_FFF0, 0);
    tbl[11] = mk(itype(6'h3F, 5'd1, 5'd2, 16'h1234), 6'd0, 5'd1, 0, 5'd0, 5'd0, 32'h0, 1);
    tbl[12] = mk(itype(6'd19, 5'd0, 5'd1, 16'h0005), 6'd19, 5'd0, 0, 5'd1, 5'd0, 32'h5, 0);
    tbl[13] = mk(rtype(6'd14, 5'd23, 5'd0, 5'd24), 6'd14, 5'd23, 1, 5'd0, 5'd24, 32'h0, 0);
    tbl[14] = mk({6'd0, 26'h155_5555}, 6'd0, 5'd10, 0, 5'd0, 5'd0, 32'h0, 0);
    tbl[15] = mk(itype(6'd23, 5'd2, 5'd3, 16'h4444), 6'd0, 5'd2, 0, 5'd0, 5'd0, 32'h0, 1);
    tbl[16] = mk(itype(6'd18, 5'd25, 5'd26, 16'hFFFF), 6'd18, 5'd25, 1, 5'd26, 5'd0, 32'h1F, 0);
    tbl[17] = mk(itype(6'd20, 5'd27, 5'd28, 16'h7FFF), 6'd20, 5'd27, 1, 5'd28, 5'd0, 32'h7FFF, 0);
    tbl[18] = mk(rtype(6'd12, 5'd29, 5'd30, 5'd31), 6'd12, 5'd29, 1, 5'd30, 5'd31, 32'h0, 0);
    tbl[19] = mk(rtype(6'd6, 5'd1, 5'd2, 5'd3), 6'd6, 5'd1, 1, 5'd2, 5'd3, 32'h0, 0);

    RST = 1'b1; FLUSH = 1'b0; EX_READY = 1'b1; WB_VALID = 1'b0; WB_RD = '0;
    fetch.IF_VALID = 1'b1; fetch.IF_INSTR = tbl[0].instr; fetch.IF_PC = '0;
    repeat (3) @(negedge CLK);
    #2;
    chk("rst_id_ready", {31'b0, fetch.ID_READY}, 32'h0);
    chk("rst_ex_valid", {31'b0, EX_VALID}, 32'h0);
    chk("rst_ex_opc", {26'b0, EX_OPC}, 32'h0);
    chk("rst_ex_imm", EX_IMM, 32'h0);
    chk("rst_ex_pc", EX_PC, 32'h0);
    chk("rst_ex_wb_en", {31'b0, EX_WB_EN}, 32'h0);
    chk("rst_illegal", {31'b0, ILLEGAL}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    fetch.IF_VALID = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i], w);
      chk("no_stall", w, 0);
      @(negedge CLK);
      fetch.IF_VALID = 1'b0;
      WB_VALID = tbl[i].wb;
      WB_RD    = tbl[i].rd;
      @(negedge CLK);
      WB_VALID = 1'b0;
      #3;
      chk("illegal_pulse_end", {31'b0, ILLEGAL}, 32'h0);
    end

    // RAW stall on r3 until its writeback has been registered.
    va = tbl[0];
    vb = tbl[1];
    drive(va, w);
    @(negedge CLK);
    fetch.IF_INSTR = vb.instr; fetch.IF_PC = pc_ctr;
    #2;
    chk("raw_stall_1", {31'b0, fetch.ID_READY}, 32'h0);
    chk("raw_rs1_addr", {27'b0, RS1_ADDR}, 32'd3);
    @(negedge CLK);
    #2;
    chk("raw_stall_2", {31'b0, fetch.ID_READY}, 32'h0);
    @(negedge CLK);
    WB_VALID = 1'b1; WB_RD = 5'd3;
    #2;
    chk("raw_stall_wb_cycle", {31'b0, fetch.ID_READY}, 32'h0);
    @(negedge CLK);
    WB_VALID = 1'b0;
    #2;
    chk("raw_release", {31'b0, fetch.ID_READY}, 32'h1);
    if (fetch.ID_READY) begin
      push(vb, pc_ctr);
      pc_ctr += 32'd4;
    end
    @(posedge CLK);
    @(negedge CLK);
    fetch.IF_VALID = 1'b0; WB_VALID = 1'b1; WB_RD = 5'd4;
    @(negedge CLK);
    WB_VALID = 1'b0;

    // Downstream backpressure: EX contents hold while EX_READY is low.
    vs = tbl[4];
    vy = tbl[2];
    drive(vs, w);
    @(negedge CLK);
    EX_READY = 1'b0;
    fetch.IF_VALID = 1'b1; fetch.IF_INSTR = vy.instr; fetch.IF_PC = pc_ctr;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("bp_id_ready", {31'b0, fetch.ID_READY}, 32'h0);
      chk("bp_ex_valid", {31'b0, EX_VALID}, 32'h1);
      chk("bp_ex_opc", {26'b0, EX_OPC}, 32'd3);
      chk("bp_ex_rs1", EX_RS1_VAL, 32'd20);
      chk("bp_ex_rs2", EX_RS2_VAL, 32'd60);
      chk("bp_ex_imm", EX_IMM, 32'h8);
      chk("bp_ex_pc", EX_PC, pc_ctr - 32'd4);
      @(negedge CLK);
    end
    EX_READY = 1'b1;
    #2;
    chk("bp_release", {31'b0, fetch.ID_READY}, 32'h1);
    if (fetch.ID_READY) begin
      push(vy, pc_ctr);
      pc_ctr += 32'd4;
    end
    @(posedge CLK);
    @(negedge CLK);
    fetch.IF_VALID = 1'b0; WB_VALID = 1'b1; WB_RD = 5'd5;
    @(negedge CLK);
    WB_VALID = 1'b0;

    // Flush squashes the in-flight r7 writer and releases its busy bit.
    va = mk(itype(6'd19, 5'd7, 5'd1, 16'h0001), 6'd19, 5'd7, 1, 5'd1, 5'd0, 32'h1, 0);
    drive(va, w);
    @(negedge CLK);
    FLUSH = 1'b1;
    fetch.IF_INSTR = itype(6'd19, 5'd9, 5'd1, 16'h0002); fetch.IF_PC = 32'hDEAD_0000;
    #2;
    chk("flush_id_ready", {31'b0, fetch.ID_READY}, 32'h0);
    chk("flush_ex_valid_before", {31'b0, EX_VALID}, 32'h1);
    if (sb.size() != 0) void'(sb.pop_back());
    @(negedge CLK);
    FLUSH = 1'b0;
    fetch.IF_VALID = 1'b0;
    #2;
    chk("flush_ex_valid_after", {31'b0, EX_VALID}, 32'h0);
    vb = mk(rtype(6'd5, 5'd8, 5'd7, 5'd0), 6'd5, 5'd8, 1, 5'd7, 5'd0, 32'h0, 0);
    drive(vb, w);
    chk("flush_move_no_stall", w, 0);
    @(negedge CLK);
    fetch.IF_VALID = 1'b0; WB_VALID = 1'b1; WB_RD = 5'd8;
    @(negedge CLK);
    WB_VALID = 1'b0;

    // Reset while a dependent instruction is stalled drops the busy state.
    va = tbl[0];
    vb = tbl[1];
    drive(va, w);
    @(negedge CLK);
    RST = 1'b1;
    fetch.IF_INSTR = vb.instr; fetch.IF_PC = pc_ctr;
    #2;
    chk("rst_mid_ready", {31'b0, fetch.ID_READY}, 32'h0);
    sb.delete();
    @(negedge CLK);
    #2;
    chk("rst_mid_ex_valid", {31'b0, EX_VALID}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    #2;
    chk("rst_mid_release", {31'b0, fetch.ID_READY}, 32'h1);
    if (fetch.ID_READY) begin
      push(vb, pc_ctr);
      pc_ctr += 32'd4;
    end
    @(posedge CLK);
    @(negedge CLK);
    fetch.IF_VALID = 1'b0; WB_VALID = 1'b1; WB_RD = 5'd4;
    @(negedge CLK);
    WB_VALID = 1'b0;

    repeat (3) @(negedge CLK);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction decode / operand-fetch stage; sits directly upstream of the RS2/immediate operand mux and the ALU.
- Splits the 32-bit instruction into fields and generates the 32-bit immediate.
- Drives register-file read addresses and tracks pending writes with a scoreboard, stalling on RAW hazards.
- Registers OPC, operands, immediate and control into an ID/EX pipeline register under a valid/ready handshake with flush.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, architectural registers; R0 reads 0 and is never busy.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- IF_VALID  input  1  IF_INSTR/IF_PC valid.
- IF_INSTR  input  32  instruction word.
- IF_PC  input  32  instruction address.
- ID_READY  output  1  combinational; instruction accepted when IF_VALID & ID_READY.
- RS1_ADDR  output  5  regfile read port 1 address (combinational).
- RS2_ADDR  output  5  regfile read port 2 address (combinational).
- RS1_DATA  input  32  regfile port 1 data (combinational read).
- RS2_DATA  input  32  regfile port 2 data.
- WB_VALID  input  1  writeback occurring this cycle.
- WB_RD  input  5  writeback destination; clears its busy bit.
- FLUSH  input  1  squash EX register and current fetch (branch/jump taken).
- EX_READY  input  1  downstream accepts EX outputs.
- EX_VALID  output  1  EX register holds a valid instruction.
- EX_OPC  output  6  opcode to operand mux/ALU.
- EX_RD  output  5  destination register.
- EX_WB_EN  output  1  instruction writes EX_RD.
- EX_RS1_VAL  output  32  operand A.
- EX_RS2_VAL  output  32  RS2 value (store data for STORE).
- EX_IMM  output  32  generated immediate.
- EX_PC  output  32  instruction PC.
- ILLEGAL  output  1  one-cycle pulse when an illegal opcode is accepted.

Behaviour:
- Fields:
  - op = [31:26]; rd = [25:21]; rs1 = [20:16]; rs2 = [15:11]; imm16 = [15:0]; tgt26 = [25:0].
  - Opcode encodings: NOP=0, ADD=1, SUB=2, STORE=3, LOAD=4, MOVE=5, SGE..SNE=6..11, AND=12, OR=13, XOR=14, NOT=15, MOVEI=16, SLI=17, SRI=18, ADDI=19, SUBI=20, JUMP=21, BRA=22.
- Sources:
  - ADD..XOR except MOVE/NOT (reg-reg): rs1 and rs2.
  - MOVE, NOT, LOAD, SLI, SRI, ADDI, SUBI, BRA: rs1 only.
  - STORE: rs1 (base), with RS2_ADDR = rd field (store data).
  - NOP, MOVEI, JUMP: none.
  - Unused ports drive address 0.
- Writeback: EX_WB_EN = 1 for ADD..NOT except STORE, and for LOAD, MOVEI, SLI, SRI, ADDI, SUBI. Forced 0 when rd = 0.
- Immediate:
  - Sign-extend imm16 for LOAD, STORE, MOVEI, ADDI, SUBI, BRA.
  - Zero-extend [4:0] for SLI/SRI.
  - Zero-extend tgt26 for JUMP.
  - 0 otherwise.
- Illegal opcode (op > 22): decoded as NOP (EX_OPC = 0, no sources, no writeback); ILLEGAL pulses for 1 cycle on acceptance.
- Scoreboard:
  - Busy vector of NREG bits; bit 0 is constant 0.
  - hazard = any used source register is busy.
  - On accept with write enable, set busy[rd].
  - On WB_VALID, clear busy[WB_RD].
  - If set and clear target the same register in the same cycle, set wins.
  - No bypass: a register cleared by WB in cycle N may be issued against in cycle N+1.
- ID_READY = !RST & !FLUSH & !hazard & (!EX_VALID | EX_READY).
- EX register update:
  - On accept: load all EX_* outputs; EX_VALID=1.
  - Else if EX_READY: EX_VALID=0; data fields hold their values.
  - Else: hold all.
  - Latency: 1 cycle from accept to EX_VALID.
- FLUSH:
  - EX_VALID <= 0 and no accept that cycle.
  - If EX_VALID & EX_WB_EN, clear busy[EX_RD] (squashed writer), unless the same-cycle WB also targets it; the result is cleared either way.
- Reset: EX_VALID, EX_OPC, EX_RD, EX_WB_EN, EX_RS1_VAL, EX_RS2_VAL, EX_IMM, EX_PC, ILLEGAL all 0; busy vector cleared. ID_READY = 0 while RST is high. Reset mid-stall discards all pending state.

Test Plan:
- Reset then ADDI r3,r1,-4 (RS1_DATA=10) -> next cycle EX_VALID=1, EX_OPC=19, EX_RD=3, EX_RS1_VAL=10, EX_IMM=0xFFFFFFFC, EX_WB_EN=1.
- ADD r4,r3,r2 directly after ADDI r3 with no WB -> ID_READY=0. Assert WB_VALID, WB_RD=3 -> ID_READY=1 the following cycle and ADD issues.
- SLI r5,r1,0x0023 -> EX_IMM=3. JUMP tgt=0x3FFFFFF -> EX_IMM=0x03FFFFFF, EX_WB_EN=0.
- EX_READY=0 for 3 cycles with EX_VALID=1 -> ID_READY=0 and all EX outputs stable; EX_READY=1 -> next instruction accepted.
- ADDI r7 issued, FLUSH next cycle -> EX_VALID=0, busy[7] cleared; subsequent MOVE r8,r7 issues without stall.
- Opcode 0x3F accepted -> ILLEGAL=1 for one cycle, EX_OPC=0, EX_WB_EN=0. ADDI r0,... -> EX_WB_EN=0 and no stall on a later r0 read.
